// File: rtl/axi_pkg.sv
// Shared AXI4 constants, bridge state encoding and the write-strobe helper
// used by the SRAM-like to AXI4 bridge.
package axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Widest strobe bus the bridge supports (DATA_W = 128).
  localparam int unsigned STRB_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

  // Byte-lane mask for a single-beat access of 2^size bytes at the given
  // lane offset; accesses as wide as the bus light every lane.
  function automatic logic [STRB_MAX-1:0] calc_strb(input logic [2:0]  size,
                                                    input logic [3:0]  offset,
                                                    input int unsigned strb_lg);
    logic [31:0] keep;
    logic [31:0] mask;
    keep = (32'd1 << (32'd1 << strb_lg)) - 32'd1;
    if (32'(size) >= strb_lg) begin
      mask = keep;
    end else begin
      mask = ((32'd1 << (32'd1 << size)) - 32'd1) << offset;
    end
    return STRB_MAX'(mask & keep);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// ptr_i, wrapping past the top port.
module rr_arbiter #(
  parameter  int unsigned NUM_PORTS = 2,
  localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic             found;
  logic [IDX_W-1:0] slot;

  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the loop can leave one holding its old value (a latch).
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    slot    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      slot = IDX_W'((32'(ptr_i) + k) % NUM_PORTS);
      if (!found && req_i[slot]) begin
        found         = 1'b1;
        grant_o[slot] = 1'b1;
        idx_o         = slot;
      end
    end
  end

endmodule

// File: rtl/axi_bridge_mp.sv
// Round-robin bridge from NUM_PORTS SRAM-like masters onto one AXI4 master
// port, with a single single-beat transaction in flight at a time.
module axi_bridge_mp
  import axi_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 2,
  parameter  int unsigned ADDR_W    = 64,
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned ID_W      = 4,
  localparam int unsigned STRB_W    = DATA_W / 8
) (
  input  logic                        clock,
  input  logic                        resetn,
  // SRAM-like slave side, one lane per master
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        wr,
  input  logic [3*NUM_PORTS-1:0]      size,
  input  logic [ADDR_W*NUM_PORTS-1:0] addr,
  input  logic [DATA_W*NUM_PORTS-1:0] wdata,
  output logic [NUM_PORTS-1:0]        addr_ok,
  output logic [NUM_PORTS-1:0]        data_ok,
  output logic [DATA_W-1:0]           rdata,
  output logic                        resp_err,
  // AXI4 read address
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arlock,
  output logic [3:0]                  arcache,
  output logic [2:0]                  arprot,
  output logic [3:0]                  arqos,
  output logic                        arvalid,
  input  logic                        arready,
  // AXI4 write address
  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awlock,
  output logic [3:0]                  awcache,
  output logic [2:0]                  awprot,
  output logic [3:0]                  awqos,
  output logic                        awvalid,
  input  logic                        awready,
  // AXI4 write data
  output logic [DATA_W-1:0]           wdata_axi,
  output logic [STRB_W-1:0]           wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  // AXI4 read data
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata_axi,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  // AXI4 write response
  input  logic [ID_W-1:0]             bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned OFF_W = $clog2(STRB_W);

  bridge_state_e        state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 aw_done_q, aw_done_d;
  logic                 w_done_q, w_done_d;
  logic                 init_q;

  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     g_idx;

  logic [IDX_W-1:0]     g_l;
  logic                 wr_l;
  logic [2:0]           size_l;
  logic [ADDR_W-1:0]    addr_l;
  logic [DATA_W-1:0]    wdata_l;

  logic                 accept;
  logic                 ar_hs, aw_hs, w_hs, resp_hs;
  logic [ID_W-1:0]      id_l;
  logic                 unused_axi;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (g_idx)
  );

  // init_q holds every handshake output low through the first cycle after reset.
  assign addr_ok = (resetn && init_q && state_q == IDLE) ? grant : '0;
  assign accept  = |(req & addr_ok);

  assign arvalid = resetn && state_q == ADDR && !wr_l;
  assign awvalid = resetn && state_q == ADDR &&  wr_l && !aw_done_q;
  assign wvalid  = resetn && state_q == ADDR &&  wr_l && !w_done_q;
  assign rready  = resetn && state_q == RESP && !wr_l;
  assign bready  = resetn && state_q == RESP &&  wr_l;

  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid  && wready;
  assign resp_hs = (rvalid && rready) || (bvalid && bready);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = ADDR;
          rr_ptr_d = (g_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : g_idx + 1'b1;
        end
      end
      ADDR: begin
        if (!wr_l) begin
          if (ar_hs) state_d = RESP;
        end else begin
          if (aw_hs) aw_done_d = 1'b1;
          if (w_hs)  w_done_d  = 1'b1;
          // AW and W complete independently; leave once both have landed.
          if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = RESP;
        end
      end
      RESP: begin
        if (resp_hs) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: flops are written with <= so each one samples pre-edge values,
    // independent of statement order.
    if (!resetn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      init_q    <= 1'b1;
    end
  end

  // NOTE: the request payload has no reset; it is only observed while
  // state_q is ADDR or RESP, which reset already clears.
  always_ff @(posedge clock) begin
    if (accept) begin
      g_l     <= g_idx;
      wr_l    <= wr[g_idx];
      size_l  <= size[32'(g_idx)*3 +: 3];
      addr_l  <= addr[32'(g_idx)*ADDR_W +: ADDR_W];
      wdata_l <= wdata[32'(g_idx)*DATA_W +: DATA_W];
    end
  end

  assign id_l = ID_W'(g_l);

  assign arid    = id_l;
  assign araddr  = addr_l;
  assign arlen   = 8'd0;
  assign arsize  = size_l;
  assign arburst = BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arqos   = 4'd0;

  assign awid    = id_l;
  assign awaddr  = addr_l;
  assign awlen   = 8'd0;
  assign awsize  = size_l;
  assign awburst = BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awqos   = 4'd0;

  assign wdata_axi = wdata_l;
  assign wstrb     = STRB_W'(calc_strb(size_l, 4'(addr_l[OFF_W-1:0]), OFF_W));
  assign wlast     = 1'b1;

  assign data_ok  = resp_hs ? (NUM_PORTS'(1) << g_l) : '0;
  assign rdata    = rdata_axi;
  assign resp_err = resp_hs && (wr_l ? (bresp[1] || bid != id_l)
                                     : (rresp[1] || rid != id_l));

  // Single-beat bursts: rlast carries no information, and resp[0] only
  // separates OKAY/EXOKAY or SLVERR/DECERR, which report identically.
  assign unused_axi = ^{rlast, rresp[0], bresp[0]};

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed bench for axi_bridge_mp: a 2-port 64-bit bridge plus a 1-port
// 32-bit instance for narrow-bus strobes.
module tb_axi_bridge_mp;

  int n_tests = 0;
  int n_fail  = 0;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  // 2-port, 64-bit instance
  logic [1:0]   req, wr, addr_ok, data_ok;
  logic [5:0]   size;
  logic [127:0] addr, wdata;
  logic [63:0]  rdata;
  logic         resp_err;
  logic [3:0]   arid, awid, rid, bid;
  logic [63:0]  araddr, awaddr, wdata_axi, rdata_axi;
  logic [7:0]   arlen, awlen, wstrb;
  logic [2:0]   arsize, awsize, arprot, awprot;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic [3:0]   arcache, awcache, arqos, awqos;
  logic         arlock, awlock, arvalid, arready, awvalid, awready;
  logic         wlast, wvalid, wready, rlast, rvalid, rready, bvalid, bready;

  // 1-port, 32-bit instance
  logic         s_req, s_wr, s_addr_ok, s_data_ok, s_resp_err;
  logic [2:0]   s_size, s_arsize, s_awsize, s_arprot, s_awprot;
  logic [31:0]  s_addr, s_wdata, s_rdata, s_araddr, s_awaddr, s_wdata_axi, s_rdata_axi;
  logic [0:0]   s_arid, s_awid, s_rid, s_bid;
  logic [7:0]   s_arlen, s_awlen;
  logic [1:0]   s_arburst, s_awburst, s_rresp, s_bresp;
  logic [3:0]   s_arcache, s_awcache, s_arqos, s_awqos, s_wstrb;
  logic         s_arlock, s_awlock, s_arvalid, s_arready, s_awvalid, s_awready;
  logic         s_wlast, s_wvalid, s_wready, s_rlast, s_rvalid, s_rready, s_bvalid, s_bready;

  logic [1:0]   exp_ok, exp_dok;

  axi_bridge_mp #(.NUM_PORTS(2), .ADDR_W(64), .DATA_W(64), .ID_W(4)) dut (
    .clock(clock), .resetn(resetn),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arvalid(arvalid), .arready(arready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awvalid(awvalid), .awready(awready),
    .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  axi_bridge_mp #(.NUM_PORTS(1), .ADDR_W(32), .DATA_W(32), .ID_W(1)) dut32 (
    .clock(clock), .resetn(resetn),
    .req(s_req), .wr(s_wr), .size(s_size), .addr(s_addr), .wdata(s_wdata),
    .addr_ok(s_addr_ok), .data_ok(s_data_ok), .rdata(s_rdata), .resp_err(s_resp_err),
    .arid(s_arid), .araddr(s_araddr), .arlen(s_arlen), .arsize(s_arsize), .arburst(s_arburst),
    .arlock(s_arlock), .arcache(s_arcache), .arprot(s_arprot), .arqos(s_arqos),
    .arvalid(s_arvalid), .arready(s_arready),
    .awid(s_awid), .awaddr(s_awaddr), .awlen(s_awlen), .awsize(s_awsize), .awburst(s_awburst),
    .awlock(s_awlock), .awcache(s_awcache), .awprot(s_awprot), .awqos(s_awqos),
    .awvalid(s_awvalid), .awready(s_awready),
    .wdata_axi(s_wdata_axi), .wstrb(s_wstrb), .wlast(s_wlast), .wvalid(s_wvalid), .wready(s_wready),
    .rid(s_rid), .rdata_axi(s_rdata_axi), .rresp(s_rresp), .rlast(s_rlast), .rvalid(s_rvalid), .rready(s_rready),
    .bid(s_bid), .bresp(s_bresp), .bvalid(s_bvalid), .bready(s_bready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0;
    req = 2'b01; wr = 2'b00; size = {3'd0, 3'd3};
    addr = {64'h0, 64'h0000_0000_8000_0008}; wdata = '0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rid = 0; bid = 0; rresp = 0; bresp = 0; rlast = 1; rdata_axi = '0;
    s_req = 0; s_wr = 0; s_size = 0; s_addr = 0; s_wdata = 0;
    s_arready = 0; s_awready = 0; s_wready = 0; s_rvalid = 0; s_bvalid = 0;
    s_rid = 0; s_bid = 0; s_rresp = 0; s_bresp = 0; s_rlast = 1; s_rdata_axi = 0;

    // Reset behaviour
    next_cycle(); next_cycle();
    sample();
    check("rst addr_ok", addr_ok, 2'b00);
    check("rst arvalid", arvalid, 1'b0);
    check("rst awvalid", awvalid, 1'b0);
    check("rst wvalid", wvalid, 1'b0);
    check("rst data_ok", data_ok, 2'b00);
    next_cycle(); resetn = 1'b1;
    sample();
    check("post-rst addr_ok", addr_ok, 2'b00);
    check("post-rst arvalid", arvalid, 1'b0);

    // Test 1: port0 read, zero-wait slave
    next_cycle();
    sample();
    check("t1 addr_ok", addr_ok, 2'b01);
    next_cycle(); req = 2'b00; arready = 1;
    sample();
    check("t1 arvalid", arvalid, 1'b1);
    check("t1 arid", arid, 4'd0);
    check("t1 araddr", araddr, 64'h8000_0008);
    check("t1 arsize", arsize, 3'd3);
    check("t1 arlen", arlen, 8'd0);
    check("t1 arburst", arburst, 2'b01);
    check("t1 addr_ok in ADDR", addr_ok, 2'b00);
    next_cycle(); arready = 0; rvalid = 1; rdata_axi = 64'hDEAD_BEEF_CAFE_F00D;
    sample();
    check("t1 rready", rready, 1'b1);
    check("t1 data_ok", data_ok, 2'b01);
    check("t1 rdata", rdata, 64'hDEAD_BEEF_CAFE_F00D);
    check("t1 resp_err", resp_err, 1'b0);
    check("t1 arvalid in RESP", arvalid, 1'b0);
    next_cycle(); rvalid = 0;
    sample();
    check("t1 data_ok pulse", data_ok, 2'b00);

    // Test 2: port1 byte write, W accepted before AW
    next_cycle();
    req = 2'b10; wr = 2'b10; size = {3'd0, 3'd3};
    addr = {64'h1003, 64'h8000_0008}; wdata = {64'h0000_0000_AA00_0000, 64'h0};
    sample();
    check("t2 addr_ok", addr_ok, 2'b10);
    next_cycle(); req = 2'b00; wready = 1;
    sample();
    check("t2 awvalid", awvalid, 1'b1);
    check("t2 wvalid", wvalid, 1'b1);
    check("t2 awid", awid, 4'd1);
    check("t2 awaddr", awaddr, 64'h1003);
    check("t2 awsize", awsize, 3'd0);
    check("t2 wstrb", wstrb, 8'b0000_1000);
    check("t2 wdata", wdata_axi, 64'hAA00_0000);
    check("t2 wlast", wlast, 1'b1);
    next_cycle(); wready = 0; awready = 1;
    sample();
    check("t2 wvalid dropped", wvalid, 1'b0);
    check("t2 awvalid held", awvalid, 1'b1);
    next_cycle(); awready = 0;
    sample();
    check("t2 awvalid in RESP", awvalid, 1'b0);
    check("t2 bready", bready, 1'b1);
    check("t2 no early data_ok", data_ok, 2'b00);
    next_cycle(); bvalid = 1; bid = 4'd1;
    sample();
    check("t2 data_ok", data_ok, 2'b10);
    check("t2 resp_err", resp_err, 1'b0);
    next_cycle(); bvalid = 0;
    sample();
    check("t2 data_ok pulse", data_ok, 2'b00);
    check("t2 bready idle", bready, 1'b0);

    // Test 3: both ports request continuously; port0 reads, port1 writes
    next_cycle();
    req = 2'b11; wr = 2'b10; size = {3'd3, 3'd3};
    addr = {64'h2000, 64'h100}; wdata = {64'h1111, 64'h2222};
    arready = 1; awready = 1; wready = 1; rvalid = 1; bvalid = 1;
    rid = 4'd0; bid = 4'd1; rdata_axi = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 12; k++) begin
      sample();
      exp_ok  = (k % 3 == 0) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_dok = (k % 3 == 2) ? (((k / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      check($sformatf("t3 addr_ok c%0d", k), addr_ok, exp_ok);
      check($sformatf("t3 data_ok c%0d", k), data_ok, exp_dok);
      if (k % 3 == 2) check($sformatf("t3 resp_err c%0d", k), resp_err, 1'b0);
      if (k == 1) check("t3 araddr", araddr, 64'h100);
      if (k == 4) check("t3 wstrb full", wstrb, 8'hFF);
      next_cycle();
    end

    // Test 4: error reporting (SLVERR read, then bid mismatch on write)
    req = 2'b01; wr = 2'b00; rresp = 2'b10; bid = 4'd3; bresp = 2'b00;
    sample();
    check("t4 addr_ok rd", addr_ok, 2'b01);
    next_cycle();
    sample();
    check("t4 arvalid", arvalid, 1'b1);
    next_cycle();
    sample();
    check("t4 rd data_ok", data_ok, 2'b01);
    check("t4 rd resp_err", resp_err, 1'b1);
    next_cycle(); wr = 2'b01; addr = {64'h2000, 64'h40};
    sample();
    check("t4 addr_ok wr", addr_ok, 2'b01);
    next_cycle(); req = 2'b00;
    sample();
    check("t4 awvalid", awvalid, 1'b1);
    check("t4 wvalid", wvalid, 1'b1);
    next_cycle();
    sample();
    check("t4 wr data_ok", data_ok, 2'b01);
    check("t4 wr resp_err", resp_err, 1'b1);
    next_cycle();
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0; rresp = 0; bid = 0;
    sample();
    check("t4 data_ok pulse", data_ok, 2'b00);

    // Test 5: reset while a write sits in ADDR
    next_cycle();
    req = 2'b10; wr = 2'b10; addr = {64'h3000, 64'h40};
    sample();
    check("t5 addr_ok", addr_ok, 2'b10);
    next_cycle(); req = 2'b00;
    sample();
    check("t5 awvalid", awvalid, 1'b1);
    check("t5 wvalid", wvalid, 1'b1);
    next_cycle(); resetn = 1'b0; req = 2'b11; bvalid = 1; bid = 4'd1;
    sample();
    check("t5 in-rst data_ok", data_ok, 2'b00);
    check("t5 in-rst addr_ok", addr_ok, 2'b00);
    check("t5 in-rst awvalid", awvalid, 1'b0);
    next_cycle();
    sample();
    check("t5 awvalid after rst", awvalid, 1'b0);
    check("t5 wvalid after rst", wvalid, 1'b0);
    check("t5 data_ok after rst", data_ok, 2'b00);
    next_cycle(); resetn = 1'b1; bvalid = 0; wr = 2'b00;
    sample();
    check("t5 post-rst addr_ok", addr_ok, 2'b00);
    check("t5 post-rst bready", bready, 1'b0);
    next_cycle();
    sample();
    check("t5 port0 first", addr_ok, 2'b01);
    next_cycle(); req = 2'b00; arready = 1;
    sample();
    check("t5 arvalid", arvalid, 1'b1);
    check("t5 arid", arid, 4'd0);
    next_cycle(); arready = 0; rvalid = 1; rid = 0; rresp = 0;
    sample();
    check("t5 data_ok", data_ok, 2'b01);
    next_cycle(); rvalid = 0;

    // Test 6: 32-bit bus strobes
    s_req = 1; s_wr = 1; s_size = 3'd2; s_addr = 32'h4; s_wdata = 32'h1234_5678;
    sample();
    check("t6 addr_ok a", s_addr_ok, 1'b1);
    next_cycle(); s_req = 0; s_awready = 1; s_wready = 1;
    sample();
    check("t6 awvalid a", s_awvalid, 1'b1);
    check("t6 wstrb word", s_wstrb, 4'b1111);
    next_cycle(); s_awready = 0; s_wready = 0; s_bvalid = 1; s_bid = 1'b0;
    sample();
    check("t6 data_ok a", s_data_ok, 1'b1);
    check("t6 resp_err a", s_resp_err, 1'b0);
    next_cycle(); s_bvalid = 0; s_req = 1; s_size = 3'd1; s_addr = 32'h2;
    sample();
    check("t6 addr_ok b", s_addr_ok, 1'b1);
    next_cycle(); s_req = 0; s_awready = 1; s_wready = 1;
    sample();
    check("t6 wstrb half", s_wstrb, 4'b1100);
    check("t6 awsize", s_awsize, 3'd1);
    next_cycle(); s_awready = 0; s_wready = 0; s_bvalid = 1;
    sample();
    check("t6 data_ok b", s_data_ok, 1'b1);
    next_cycle(); s_bvalid = 0;
    sample();
    check("t6 data_ok pulse", s_data_ok, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
